// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
// The optional starvation guard is enabled with DMEM_ARB_STARVE_EN.
package dmem_arb_pkg;

  localparam int DEF_ADDR_W       = 6;
  localparam int DEF_MAX_LEN      = 16;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int LEN_W            = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dmem_arb_burst_ctr.sv
// DMA burst address pointer and remaining-beat counter.
// Loads at burst start, advances once per beat, wraps at the top of memory.
module dmem_arb_burst_ctr
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int MAX_LEN = DEF_MAX_LEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              step,
  output logic [ADDR_W-1:0] ptr,
  output logic              last
);

  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

  logic [ADDR_W-1:0] ptr_r;
  logic [LEN_W-1:0]  remain_r;
  logic [LEN_W-1:0]  load_len_s;

  // clamp requested burst length to the supported maximum
  always_comb begin
    load_len_s = load_len;
    if (load_len > MAX_LEN_C) begin
      load_len_s = MAX_LEN_C;
    end else begin
      load_len_s = load_len;
    end
  end

  // pointer and remaining-count registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_r    <= {ADDR_W{1'b0}};
      remain_r <= {LEN_W{1'b0}};
    end else if (load) begin
      ptr_r    <= load_addr;
      remain_r <= load_len_s;
    end else if (step) begin
      ptr_r    <= ptr_r + ADDR_W'(1'b1);
      remain_r <= remain_r - LEN_W'(1'b1);
    end else begin
      ptr_r    <= ptr_r;
      remain_r <= remain_r;
    end
  end

  assign ptr  = ptr_r;
  assign last = (remain_r == LEN_W'(1'b1));

endmodule

// File: rtl/dmem_arbiter.sv
// Core / DMA arbiter and burst sequencer for the single-port data memory.
// Define DMEM_ARB_STARVE_EN to force a DMA beat after STARVE_LIMIT core wins.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int MAX_LEN = DEF_MAX_LEN
`ifdef DMEM_ARB_STARVE_EN
  ,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [31:0]       c_wdata,
  output logic              c_gnt,
  output logic [31:0]       c_rdata,
  output logic              c_rvalid,
  input  logic              b_start,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [LEN_W-1:0]  b_len,
  input  logic [31:0]       b_wdata,
  output logic              b_beat,
  output logic [31:0]       b_rdata,
  output logic              b_rvalid,
  output logic              b_busy,
  output logic              b_done,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  arb_state_e        state_r, next_state_s;
  logic              dir_r;
  logic              force_s, gnt_s, beat_s, load_s, last_s;
  logic [ADDR_W-1:0] ptr_s;
  logic [31:0]       c_rdata_r, b_rdata_r;
  logic              c_rvalid_r, b_rvalid_r, b_done_r;

  dmem_arb_burst_ctr #(
    .ADDR_W  (ADDR_W),
    .MAX_LEN (MAX_LEN)
  ) u_burst_ctr (
    .clk       (clk),
    .reset     (reset),
    .load      (load_s),
    .load_addr (b_addr),
    .load_len  (b_len),
    .step      (beat_s),
    .ptr       (ptr_s),
    .last      (last_s)
  );

`ifdef DMEM_ARB_STARVE_EN
  localparam logic [2:0] STARVE_LIMIT_C = 3'(STARVE_LIMIT);
  logic [2:0] starve_cnt_r;

  // consecutive core wins while a burst is waiting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_r <= 3'd0;
    end else if ((state_r != ST_BURST) || beat_s) begin
      starve_cnt_r <= 3'd0;
    end else if (gnt_s) begin
      starve_cnt_r <= starve_cnt_r + 3'd1;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  assign force_s = (state_r == ST_BURST) && (starve_cnt_r == STARVE_LIMIT_C);
`else
  assign force_s = 1'b0;
`endif

  // arbitration, next-state logic and memory port mux
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    gnt_s        = reset && c_req && !force_s;
    beat_s       = reset && (state_r == ST_BURST) && !gnt_s;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = {ADDR_W{1'b0}};
    mem_wdata    = 32'd0;
    case (state_r)
      ST_IDLE: begin
        if (b_start && (b_len != {LEN_W{1'b0}})) begin
          next_state_s = ST_BURST;
          load_s       = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (beat_s && last_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_BURST;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
    if (gnt_s) begin
      mem_addr  = c_addr;
      mem_read  = !c_we;
      mem_write = c_we;
      mem_wdata = c_wdata;
    end else if (beat_s) begin
      mem_addr  = ptr_s;
      mem_read  = !dir_r;
      mem_write = dir_r;
      mem_wdata = b_wdata;
    end else begin
      mem_addr  = {ADDR_W{1'b0}};
    end
  end

  // FSM state and latched burst direction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      dir_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      dir_r   <= load_s ? b_we : dir_r;
    end
  end

  // read-data capture, valid pulses and burst completion pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_rdata_r  <= 32'd0;
      b_rdata_r  <= 32'd0;
      c_rvalid_r <= 1'b0;
      b_rvalid_r <= 1'b0;
      b_done_r   <= 1'b0;
    end else begin
      c_rvalid_r <= gnt_s && !c_we;
      b_rvalid_r <= beat_s && !dir_r;
      b_done_r   <= beat_s && last_s;
      c_rdata_r  <= (gnt_s && !c_we) ? mem_rdata : c_rdata_r;
      b_rdata_r  <= (beat_s && !dir_r) ? mem_rdata : b_rdata_r;
    end
  end

  assign c_gnt    = gnt_s;
  assign b_beat   = beat_s;
  assign b_busy   = (state_r == ST_BURST);
  assign c_rdata  = c_rdata_r;
  assign c_rvalid = c_rvalid_r;
  assign b_rdata  = b_rdata_r;
  assign b_rvalid = b_rvalid_r;
  assign b_done   = b_done_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic
// compared against a transaction-level model of memory, bursts and arbitration.
module tb_dmem_arbiter;

  localparam int AW   = 6;
  localparam int MAXL = 16;
  localparam int SLIM = 4;
`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          c_req, c_we, c_gnt, c_rvalid;
  logic [AW-1:0] c_addr;
  logic [31:0]   c_wdata, c_rdata;
  logic          b_start, b_we, b_beat, b_rvalid, b_busy, b_done;
  logic [AW-1:0] b_addr;
  logic [4:0]    b_len;
  logic [31:0]   b_wdata, b_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  logic [31:0] mem [64];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rdata(c_rdata), .c_rvalid(c_rvalid),
    .b_start(b_start), .b_we(b_we), .b_addr(b_addr), .b_len(b_len),
    .b_wdata(b_wdata), .b_beat(b_beat), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .b_busy(b_busy), .b_done(b_done),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [31:0] ref_mem [64];
  bit          m_busy, m_dir;
  int          m_ptr, m_left, m_wins;
  bit          e_gnt, e_beat, e_c_rv, e_b_rv, e_done;
  logic [31:0] e_c_rd, e_b_rd;
  int          e_addr;

  task automatic model_reset();
    m_busy = 1'b0; m_dir = 1'b0; m_ptr = 0; m_left = 0; m_wins = 0;
    e_c_rv = 1'b0; e_b_rv = 1'b0; e_done = 1'b0; e_c_rd = 32'd0; e_b_rd = 32'd0;
  endtask

  task automatic model_eval();
    bit frc;
    frc    = STARVE && m_busy && (m_wins == SLIM);
    e_gnt  = c_req && !frc;
    e_beat = m_busy && (!c_req || frc);
    e_addr = e_gnt ? int'(c_addr) : m_ptr;
  endtask

  task automatic model_update();
    bit was_busy;
    was_busy = m_busy;
    e_c_rv = e_gnt && !c_we;
    if (e_gnt && c_we) ref_mem[c_addr] = c_wdata;
    if (e_c_rv) e_c_rd = ref_mem[c_addr];
    e_b_rv = e_beat && !m_dir;
    e_done = e_beat && (m_left == 1);
    if (e_beat) begin
      if (m_dir) ref_mem[m_ptr] = b_wdata;
      else e_b_rd = ref_mem[m_ptr];
      m_ptr  = (m_ptr + 1) % 64;
      m_left = m_left - 1;
      m_wins = 0;
      if (m_left == 0) m_busy = 1'b0;
    end else if (m_busy && e_gnt) begin
      m_wins = m_wins + 1;
    end
    if (!was_busy) begin
      m_wins = 0;
      if (b_start && (b_len != 5'd0)) begin
        m_busy = 1'b1;
        m_ptr  = int'(b_addr);
        m_left = (int'(b_len) > MAXL) ? MAXL : int'(b_len);
        m_dir  = b_we;
      end
    end
  endtask

  task automatic settle();
    model_eval();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    c_req = 1'b0; c_we = 1'b0; c_addr = 6'd0; c_wdata = 32'd0;
    b_start = 1'b0; b_we = 1'b0; b_addr = 6'd0; b_len = 5'd0; b_wdata = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    c_req = 1'b1; c_we = 1'b1; c_addr = 6'd7; c_wdata = 32'h1234;
    #1 reset = 1'b0;
    #1;
    n_checks++; if ({c_gnt, b_beat, mem_read, mem_write, b_busy, b_done, c_rvalid, b_rvalid} !== 8'd0) begin n_errors++; $display("FAIL reset_ctrl: got %b expected 00000000", {c_gnt, b_beat, mem_read, mem_write, b_busy, b_done, c_rvalid, b_rvalid}); end
    n_checks++; if ({mem_addr, mem_wdata} !== 38'd0) begin n_errors++; $display("FAIL reset_mem_bus: got %h expected 0", {mem_addr, mem_wdata}); end
    n_checks++; if ({c_rdata, b_rdata} !== 64'd0) begin n_errors++; $display("FAIL reset_rdata: got %h expected 0", {c_rdata, b_rdata}); end
    model_reset();
    @(posedge clk); #1;
    idle_inputs();
    reset = 1'b1;
  endtask

  task automatic test_core_rw();
    c_req = 1'b1; c_we = 1'b1; c_addr = 6'd5; c_wdata = 32'hDEADBEEF;
    settle();
    n_checks++; if (c_gnt !== 1'b1 || mem_write !== 1'b1) begin n_errors++; $display("FAIL core_wr_gnt: got gnt=%b wr=%b expected 1 1", c_gnt, mem_write); end
    n_checks++; if (mem_addr !== 6'd5 || mem_wdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL core_wr_bus: got %0d/%h expected 5/deadbeef", mem_addr, mem_wdata); end
    n_checks++; if (b_busy !== 1'b0) begin n_errors++; $display("FAIL core_busy: got %b expected 0", b_busy); end
    advance();
    c_we = 1'b0;
    settle();
    n_checks++; if (c_gnt !== 1'b1 || mem_read !== 1'b1 || mem_write !== 1'b0) begin n_errors++; $display("FAIL core_rd_gnt: got gnt=%b rd=%b wr=%b expected 1 1 0", c_gnt, mem_read, mem_write); end
    n_checks++; if (c_rvalid !== 1'b0) begin n_errors++; $display("FAIL core_wr_no_rvalid: got %b expected 0", c_rvalid); end
    advance();
    idle_inputs();
    settle();
    n_checks++; if (c_rvalid !== 1'b1 || c_rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL core_rd_data: got v=%b %h expected 1 deadbeef", c_rvalid, c_rdata); end
    advance();
    settle();
    n_checks++; if (c_rvalid !== 1'b0 || c_rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL core_rd_hold: got v=%b %h expected 0 deadbeef", c_rvalid, c_rdata); end
    advance();
  endtask

  task automatic test_dma_wrap();
    logic [AW-1:0] a;
    idle_inputs();
    b_start = 1'b1; b_we = 1'b1; b_addr = 6'd62; b_len = 5'd4;
    settle();
    n_checks++; if (b_beat !== 1'b0 || b_busy !== 1'b0) begin n_errors++; $display("FAIL wrap_start_cycle: got beat=%b busy=%b expected 0 0", b_beat, b_busy); end
    advance();
    b_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_wdata = 32'(i + 1);
      a = 6'(62 + i);
      settle();
      n_checks++; if (b_beat !== 1'b1 || mem_write !== 1'b1 || b_busy !== 1'b1) begin n_errors++; $display("FAIL wrap_beat%0d: got beat=%b wr=%b busy=%b expected 1 1 1", i, b_beat, mem_write, b_busy); end
      n_checks++; if (mem_addr !== a || mem_wdata !== 32'(i + 1)) begin n_errors++; $display("FAIL wrap_addr%0d: got %0d/%0d expected %0d/%0d", i, mem_addr, mem_wdata, a, i + 1); end
      advance();
    end
    settle();
    n_checks++; if (b_done !== 1'b1 || b_busy !== 1'b0) begin n_errors++; $display("FAIL wrap_done: got done=%b busy=%b expected 1 0", b_done, b_busy); end
    advance();
    b_start = 1'b1; b_we = 1'b0; b_addr = 6'd62; b_len = 5'd4;
    settle();
    n_checks++; if (b_done !== 1'b0 || b_beat !== 1'b0) begin n_errors++; $display("FAIL wrap_done_pulse: got done=%b beat=%b expected 0 0", b_done, b_beat); end
    advance();
    b_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      if (i < 4) begin
        n_checks++; if (b_beat !== 1'b1 || mem_read !== 1'b1) begin n_errors++; $display("FAIL rdburst_beat%0d: got beat=%b rd=%b expected 1 1", i, b_beat, mem_read); end
      end
      if (i > 0) begin
        n_checks++; if (b_rvalid !== 1'b1 || b_rdata !== 32'(i)) begin n_errors++; $display("FAIL rdburst_data%0d: got v=%b %0d expected 1 %0d", i, b_rvalid, b_rdata, i); end
      end
      if (i == 4) begin
        n_checks++; if (b_done !== 1'b1) begin n_errors++; $display("FAIL rdburst_done: got %b expected 1", b_done); end
      end
      advance();
    end
  endtask

  task automatic test_core_starve();
    idle_inputs();
    b_start = 1'b1; b_we = 1'b0; b_addr = 6'd62; b_len = 5'd3;
    c_req = 1'b1;
    settle();
    advance();
    b_start = 1'b0;
`ifdef DMEM_ARB_STARVE_EN
    for (int k = 0; k < 15; k++) begin
      c_addr = 6'($urandom);
      settle();
      n_checks++; if (b_beat !== (k % 5 == 4) || c_gnt !== (k % 5 != 4)) begin n_errors++; $display("FAIL starve_pattern k=%0d: got beat=%b gnt=%b expected %b %b", k, b_beat, c_gnt, (k % 5 == 4), (k % 5 != 4)); end
      n_checks++; if (b_rvalid !== (k % 5 == 0 && k > 0)) begin n_errors++; $display("FAIL starve_rvalid k=%0d: got %b expected %b", k, b_rvalid, (k % 5 == 0 && k > 0)); end
      advance();
    end
    settle();
    n_checks++; if (b_done !== 1'b1 || b_busy !== 1'b0 || b_rdata !== 32'd3) begin n_errors++; $display("FAIL starve_done: got done=%b busy=%b data=%0d expected 1 0 3", b_done, b_busy, b_rdata); end
    advance();
    idle_inputs();
`else
    for (int k = 0; k < 12; k++) begin
      c_addr = 6'($urandom);
      settle();
      n_checks++; if (b_beat !== 1'b0 || b_busy !== 1'b1 || c_gnt !== 1'b1) begin n_errors++; $display("FAIL prio_hold k=%0d: got beat=%b busy=%b gnt=%b expected 0 1 1", k, b_beat, b_busy, c_gnt); end
      advance();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      settle();
      if (i < 3) begin
        n_checks++; if (b_beat !== 1'b1) begin n_errors++; $display("FAIL prio_release_beat%0d: got %b expected 1", i, b_beat); end
      end
      if (i > 0) begin
        n_checks++; if (b_rvalid !== 1'b1 || b_rdata !== 32'(i)) begin n_errors++; $display("FAIL prio_data%0d: got v=%b %0d expected 1 %0d", i, b_rvalid, b_rdata, i); end
      end
      if (i == 3) begin
        n_checks++; if (b_done !== 1'b1 || b_busy !== 1'b0) begin n_errors++; $display("FAIL prio_done: got done=%b busy=%b expected 1 0", b_done, b_busy); end
      end
      advance();
    end
`endif
  endtask

  task automatic test_ignored_start();
    idle_inputs();
    b_start = 1'b1; b_len = 5'd0; b_addr = 6'd9; b_we = 1'b1;
    settle();
    advance();
    b_start = 1'b0;
    settle();
    n_checks++; if (b_busy !== 1'b0 || b_beat !== 1'b0 || b_done !== 1'b0) begin n_errors++; $display("FAIL zero_len: got busy=%b beat=%b done=%b expected 0 0 0", b_busy, b_beat, b_done); end
    advance();
    b_start = 1'b1; b_len = 5'd3; b_addr = 6'd20; b_we = 1'b1;
    settle();
    advance();
    for (int i = 0; i < 3; i++) begin
      b_wdata = $urandom;
      if (i == 1) begin b_start = 1'b1; b_addr = 6'd40; b_len = 5'd7; b_we = 1'b0; end
      else begin b_start = 1'b0; end
      settle();
      n_checks++; if (b_beat !== 1'b1 || mem_write !== 1'b1 || mem_addr !== 6'(20 + i) || b_busy !== 1'b1) begin n_errors++; $display("FAIL restart_beat%0d: got beat=%b wr=%b addr=%0d busy=%b expected 1 1 %0d 1", i, b_beat, mem_write, mem_addr, b_busy, 20 + i); end
      advance();
    end
    b_start = 1'b0;
    settle();
    n_checks++; if (b_done !== 1'b1 || b_busy !== 1'b0) begin n_errors++; $display("FAIL restart_done: got done=%b busy=%b expected 1 0", b_done, b_busy); end
    advance();
  endtask

  task automatic test_reset_mid_burst();
    idle_inputs();
    b_start = 1'b1; b_len = 5'd5; b_addr = 6'd30; b_we = 1'b1;
    settle();
    advance();
    b_start = 1'b0;
    b_wdata = $urandom;
    settle();
    advance();
    b_wdata = $urandom;
    settle();
    n_checks++; if (b_beat !== 1'b1 || mem_addr !== 6'd31) begin n_errors++; $display("FAIL abort_beat2: got beat=%b addr=%0d expected 1 31", b_beat, mem_addr); end
    #1 reset = 1'b0;
    #1;
    n_checks++; if ({b_beat, b_busy, mem_write, mem_read, c_gnt, b_done, b_rvalid, c_rvalid} !== 8'd0 || mem_addr !== 6'd0) begin n_errors++; $display("FAIL abort_outputs: got %b addr=%0d expected 00000000 0", {b_beat, b_busy, mem_write, mem_read, c_gnt, b_done, b_rvalid, c_rvalid}, mem_addr); end
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      settle();
      n_checks++; if (b_busy !== 1'b0 || b_done !== 1'b0 || b_beat !== 1'b0) begin n_errors++; $display("FAIL abort_after k=%0d: got busy=%b done=%b beat=%b expected 0 0 0", k, b_busy, b_done, b_beat); end
      advance();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      c_req   = ($urandom_range(0, 99) < 45);
      c_we    = 1'($urandom_range(0, 1));
      c_addr  = 6'($urandom);
      c_wdata = $urandom;
      b_start = ($urandom_range(0, 9) == 0);
      b_we    = 1'($urandom_range(0, 1));
      b_addr  = 6'($urandom);
      b_len   = 5'($urandom_range(0, 20));
      b_wdata = $urandom;
      settle();
      n_checks++; if (c_gnt !== e_gnt || b_beat !== e_beat || b_busy !== m_busy) begin n_errors++; $display("FAIL rand_arb n=%0d: got gnt=%b beat=%b busy=%b expected %b %b %b", n, c_gnt, b_beat, b_busy, e_gnt, e_beat, m_busy); end
      n_checks++; if (c_rvalid !== e_c_rv || b_rvalid !== e_b_rv || b_done !== e_done) begin n_errors++; $display("FAIL rand_pulses n=%0d: got crv=%b brv=%b done=%b expected %b %b %b", n, c_rvalid, b_rvalid, b_done, e_c_rv, e_b_rv, e_done); end
      n_checks++; if (c_rdata !== e_c_rd || b_rdata !== e_b_rd) begin n_errors++; $display("FAIL rand_rdata n=%0d: got %h %h expected %h %h", n, c_rdata, b_rdata, e_c_rd, e_b_rd); end
      if (e_gnt || e_beat) begin
        n_checks++; if (mem_addr !== 6'(e_addr) || mem_write !== (e_gnt ? c_we : m_dir)) begin n_errors++; $display("FAIL rand_bus n=%0d: got addr=%0d wr=%b expected %0d %b", n, mem_addr, mem_write, e_addr, (e_gnt ? c_we : m_dir)); end
      end
      advance();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'd0;
      ref_mem[i] = 32'd0;
    end
    model_reset();
    test_reset();
    test_core_rw();
    test_dma_wrap();
    test_core_starve();
    test_ignored_start();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and burst sequencer in front of the single-port data memory (64 × 32, sync write, async read). It shares the memory between the core load/store port and a DMA burst port, and grants at most one access per cycle. It also generates DMA word addresses and registers read data for both requesters. It sits between the core MEM stage / DMA engine and the memory's MemRead/MemWrite/Address/write_data/Read_Data pins.

## Interface
- ADDR_W, 6, word-address width (memory depth 2^ADDR_W)
- MAX_LEN, 16, maximum DMA burst length in words
- STARVE_LIMIT, 4, consecutive core wins before a pending DMA beat is forced (only with DMEM_ARB_STARVE_EN)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- c_req / c_we  in  1 / 1  core access request / write when 1, read when 0
- c_addr / c_wdata  in  ADDR_W / 32  core word address / write data
- c_gnt  out  1  core access performed this cycle (combinational)
- c_rdata / c_rvalid  out  32 / 1  core read data / valid, registered
- b_start / b_we  in  1 / 1  DMA burst start pulse / burst direction
- b_addr / b_len  in  ADDR_W / 5  DMA start word address / length (1..MAX_LEN)
- b_wdata  in  32  DMA write word for the current beat
- b_beat  out  1  DMA beat performed this cycle; b_wdata is consumed on this cycle
- b_rdata / b_rvalid  out  32 / 1  DMA read word / valid, registered
- b_busy / b_done  out  1 / 1  burst in progress / one-cycle completion pulse
- mem_read, mem_write  out  1 each  to memory MemRead/MemWrite
- mem_addr / mem_wdata  out  ADDR_W / 32  to memory Address / write_data
- mem_rdata  in  32  from memory Read_Data

## Operation
- FSM states: IDLE and BURST. Reset state is IDLE.
- IDLE → BURST: b_start=1 and b_len≠0 at the clock edge. This latches ptr=b_addr, remain=min(b_len, MAX_LEN), and the direction from b_we.
- In IDLE, b_start with b_len=0 is ignored. No b_done is produced.
- b_start while in BURST is ignored.
- Arbitration each cycle:
  - Core wins whenever c_req=1, unless force=1.
  - The DMA beat is issued when in BURST and (c_req=0 or force=1).
  - force is defined only with the starvation feature; otherwise it is 0.
- Winner drives mem_* combinationally; with no winner, mem_read=mem_write=0.
  - Core grant: mem_addr=c_addr, mem_read=!c_we, mem_write=c_we, mem_wdata=c_wdata.
  - DMA beat: mem_addr=ptr, mem_write=burst direction, mem_read=!direction, mem_wdata=b_wdata.
- On each DMA beat: ptr ← ptr+1 modulo 2^ADDR_W (wraps 63→0), remain ← remain−1.
- The beat with remain=1 returns the FSM to IDLE. b_done=1 on the following cycle.
- Read responses: c_rdata / b_rdata are loaded from mem_rdata on a granted read. c_rvalid / b_rvalid are pulsed the next cycle.
- rdata registers hold their last value otherwise.
- A write grant produces no rvalid.

## Timing
- Grant to memory write: same rising edge as the grant cycle.
- Grant to rdata/rvalid: 1 cycle.
- b_start to first possible beat: 1 cycle.
- Last beat to b_done: 1 cycle. On a read burst, b_done and the final b_rvalid are in the same cycle.
- b_busy=1 exactly while in BURST.
- All outputs reset to 0, except combinational mem_*/gnt, which are 0 while reset is held. Counters and pointers also reset to 0.
- Reset asserted mid-burst aborts immediately. No b_done; pending rvalid is dropped.

## Configuration
- DMEM_ARB_STARVE_EN defined:
  - A 3-bit starvation counter increments on each BURST cycle where the core wins.
  - When the counter equals STARVE_LIMIT, force=1 for the next cycle, which grants the DMA beat and stalls the core (c_gnt=0).
  - The counter clears on any DMA beat and in IDLE.
- Undefined: strict core priority, with no counter and force=0. A DMA burst may starve indefinitely.

## Structure
- Package dmem_arb_pkg: state enum (ST_IDLE, ST_BURST), default ADDR_W, MAX_LEN, STARVE_LIMIT, LEN_W=5.
- One sub-module: dmem_arb_burst_ctr, which holds ptr/remain loading, increment, wrap and the last-beat flag.
- Arbitration, FSM and response registers live in the top module.

## Test plan
- Reset, then core write addr 5 data 0xDEADBEEF, then core read addr 5. Required: c_gnt=1 on both cycles, and c_rvalid=1 with c_rdata=0xDEADBEEF one cycle after the read grant.
- DMA write burst, b_addr=62, b_len=4, data 1..4, no core traffic. Required:
  - four consecutive b_beat cycles at addresses 62, 63, 0, 1;
  - b_done one cycle after the 4th beat;
  - a following read burst from the same start address returns 1..4 on b_rvalid.
- Core c_req held continuously during a b_len=3 read burst, without DMEM_ARB_STARVE_EN. Required: b_beat never asserts and b_busy stays 1. After c_req drops, three beats complete.
- Same stimulus with DMEM_ARB_STARVE_EN and STARVE_LIMIT=4. Required: the core wins 4 cycles, then a 1-cycle core stall with b_beat=1, and the pattern repeats until b_done.
- b_start with b_len=0, and a second b_start mid-burst. Required: both are ignored; b_busy/b_done and the pointer are unaffected.
- Reset asserted on the 2nd beat of a 5-word burst. Required: all outputs go to 0 immediately, the FSM is in IDLE after release, and no b_done is ever seen.
